// File: rtl/mc_ctrl_pkg.sv
// Shared opcode, state and control-code definitions for the multi-cycle MIPS control unit.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_EXECUTE = 4'd7,
        ST_ALUWB   = 4'd8,
        ST_BEQ     = 4'd9,
        ST_ADDIEX  = 4'd10,
        ST_ADDIWB  = 4'd11,
        ST_JUMP    = 4'd12
    } state_e;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: registered state (plus mem_ready in FETCH) to datapath controls.
module mc_output_decode
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 2
) (
    input  state_e              i_state,
    input  logic                i_mem_ready,
    input  logic                i_op_illegal,
    output logic                o_iord_c,
    output logic                o_mem_write_c,
    output logic                o_ir_write_c,
    output logic                o_pc_write_c,
    output logic                o_branch_c,
    output logic [1:0]          o_pc_src_c,
    output logic                o_alu_src_a_c,
    output logic [1:0]          o_alu_src_b_c,
    output logic [ALUOP_W-1:0]  o_alu_op_c,
    output logic                o_reg_write_c,
    output logic                o_mem_to_reg_c,
    output logic                o_reg_dest_c,
    output logic                o_illegal_op_c,
    output logic                o_busy_c
);

    always_comb begin
        o_iord_c       = 1'b0;
        o_mem_write_c  = 1'b0;
        o_ir_write_c   = 1'b0;
        o_pc_write_c   = 1'b0;
        o_branch_c     = 1'b0;
        o_pc_src_c     = PCSRC_ALU;
        o_alu_src_a_c  = 1'b0;
        o_alu_src_b_c  = SRCB_REGB;
        o_alu_op_c     = ALUOP_W'(ALUOP_ADD);
        o_reg_write_c  = 1'b0;
        o_mem_to_reg_c = 1'b0;
        o_reg_dest_c   = 1'b0;
        o_illegal_op_c = 1'b0;
        o_busy_c       = (i_state != ST_IDLE);

        case (i_state)
            // PC + 4 computed every fetch cycle; only committed once memory delivers
            ST_FETCH: begin
                o_alu_src_b_c = SRCB_FOUR;
                o_ir_write_c  = i_mem_ready;
                o_pc_write_c  = i_mem_ready;
            end
            ST_DECODE: begin
                o_alu_src_b_c  = SRCB_IMMSH;
                o_illegal_op_c = i_op_illegal;
            end
            ST_MEMADR: begin
                o_alu_src_a_c = 1'b1;
                o_alu_src_b_c = SRCB_IMM;
            end
            ST_MEMRD: begin
                o_iord_c = 1'b1;
            end
            ST_MEMWB: begin
                o_reg_write_c  = 1'b1;
                o_mem_to_reg_c = 1'b1;
            end
            ST_MEMWR: begin
                o_iord_c      = 1'b1;
                o_mem_write_c = 1'b1;
            end
            ST_EXECUTE: begin
                o_alu_src_a_c = 1'b1;
                o_alu_op_c    = ALUOP_W'(ALUOP_FUNCT);
            end
            ST_ALUWB: begin
                o_reg_write_c = 1'b1;
                o_reg_dest_c  = 1'b1;
            end
            ST_BEQ: begin
                o_alu_src_a_c = 1'b1;
                o_alu_op_c    = ALUOP_W'(ALUOP_SUB);
                o_branch_c    = 1'b1;
                o_pc_src_c    = PCSRC_ALUOUT;
            end
            ST_ADDIEX: begin
                o_alu_src_a_c = 1'b1;
                o_alu_src_b_c = SRCB_IMM;
            end
            ST_ADDIWB: begin
                o_reg_write_c = 1'b1;
            end
            ST_JUMP: begin
                o_pc_write_c = 1'b1;
                o_pc_src_c   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control unit: state register and next-state sequencing over shared memory and ALU.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned ALUOP_W     = 2,
    parameter bit          MEM_HANDSHK = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                iord,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                reg_dest,
    output logic                illegal_op,
    output logic                busy
);

    state_e r_state;
    state_e w_state_nxt;
    logic   w_mem_ready;
    logic   w_op_illegal;

    // Without a handshake every memory access completes in one cycle
    assign w_mem_ready = MEM_HANDSHK ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = ST_IDLE;
        w_op_illegal = 1'b0;

        case (r_state)
            ST_IDLE:    w_state_nxt = en ? ST_FETCH : ST_IDLE;
            ST_FETCH:   w_state_nxt = w_mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) begin
                    w_state_nxt = ST_MEMADR;
                end else if (opcode == OPCODE_W'(OP_RTYPE)) begin
                    w_state_nxt = ST_EXECUTE;
                end else if (opcode == OPCODE_W'(OP_BEQ)) begin
                    w_state_nxt = ST_BEQ;
                end else if (opcode == OPCODE_W'(OP_ADDI)) begin
                    w_state_nxt = ST_ADDIEX;
                end else if (opcode == OPCODE_W'(OP_J)) begin
                    w_state_nxt = ST_JUMP;
                end else begin
                    // PC already advanced in FETCH, so the bad instruction is simply skipped
                    w_op_illegal = 1'b1;
                    w_state_nxt  = ST_FETCH;
                end
            end
            ST_MEMADR:  w_state_nxt = (opcode == OPCODE_W'(OP_LW)) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:   w_state_nxt = w_mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:   w_state_nxt = ST_FETCH;
            ST_MEMWR:   w_state_nxt = w_mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXECUTE: w_state_nxt = ST_ALUWB;
            ST_ALUWB:   w_state_nxt = ST_FETCH;
            ST_BEQ:     w_state_nxt = ST_FETCH;
            ST_ADDIEX:  w_state_nxt = ST_ADDIWB;
            ST_ADDIWB:  w_state_nxt = ST_FETCH;
            ST_JUMP:    w_state_nxt = ST_FETCH;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    mc_output_decode #(
        .ALUOP_W (ALUOP_W)
    ) u_output_decode (
        .i_state        (r_state),
        .i_mem_ready    (w_mem_ready),
        .i_op_illegal   (w_op_illegal),
        .o_iord_c       (iord),
        .o_mem_write_c  (mem_write),
        .o_ir_write_c   (ir_write),
        .o_pc_write_c   (pc_write),
        .o_branch_c     (branch),
        .o_pc_src_c     (pc_src),
        .o_alu_src_a_c  (alu_src_a),
        .o_alu_src_b_c  (alu_src_b),
        .o_alu_op_c     (alu_op),
        .o_reg_write_c  (reg_write),
        .o_mem_to_reg_c (mem_to_reg),
        .o_reg_dest_c   (reg_dest),
        .o_illegal_op_c (illegal_op),
        .o_busy_c       (busy)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-cycle control words from an instruction-level model, plus latency and reset scenarios.
module tb_multicycle_control_fsm;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BAD  = 6'b111111;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dest;
        logic       illegal;
        logic       busy;
    } ctl_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       iord, mem_write, ir_write, pc_write, branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write, mem_to_reg, reg_dest, illegal_op, busy;

    int   checks;
    int   failures;
    int   cnt_mem_write;
    int   cnt_reg_write;
    int   cnt_illegal;
    ctl_t q_exp[$];
    logic q_mr[$];

    multicycle_control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .reg_dest   (reg_dest),
        .illegal_op (illegal_op),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t observe();
        ctl_t c;
        c.iord       = iord;
        c.mem_write  = mem_write;
        c.ir_write   = ir_write;
        c.pc_write   = pc_write;
        c.branch     = branch;
        c.pc_src     = pc_src;
        c.src_a      = alu_src_a;
        c.src_b      = alu_src_b;
        c.alu_op     = alu_op;
        c.reg_write  = reg_write;
        c.mem_to_reg = mem_to_reg;
        c.reg_dest   = reg_dest;
        c.illegal    = illegal_op;
        c.busy       = busy;
        return c;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return (op == T_R) || (op == T_LW) || (op == T_SW) ||
               (op == T_BEQ) || (op == T_ADDI) || (op == T_J);
    endfunction

    // mem_ready in a cycle where the controller should not care about it
    function automatic logic dont_care_mr(input bit tie);
        return tie ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    function automatic ctl_t active();
        ctl_t c = '0;
        c.busy = 1'b1;
        return c;
    endfunction

    function automatic void push(input logic mr, input ctl_t c);
        q_mr.push_back(mr);
        q_exp.push_back(c);
    endfunction

    // Instruction-level model: expected controls for every cycle from FETCH up to the next FETCH
    function automatic void build(input logic [5:0] op, input int fw, input int mw, input bit tie);
        ctl_t c;
        logic r;
        q_mr.delete();
        q_exp.delete();
        for (int i = 0; i <= fw; i++) begin
            r = (i == fw);
            c = active();
            c.src_b    = 2'b01;
            c.ir_write = r;
            c.pc_write = r;
            push(r, c);
        end
        c = active();
        c.src_b   = 2'b11;
        c.illegal = !is_legal(op);
        push(dont_care_mr(tie), c);
        if (op == T_LW || op == T_SW) begin
            c = active();
            c.src_a = 1'b1;
            c.src_b = 2'b10;
            push(dont_care_mr(tie), c);
            for (int i = 0; i <= mw; i++) begin
                c = active();
                c.iord      = 1'b1;
                c.mem_write = (op == T_SW);
                push(i == mw, c);
            end
            if (op == T_LW) begin
                c = active();
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                push(dont_care_mr(tie), c);
            end
        end else if (op == T_R) begin
            c = active();
            c.src_a  = 1'b1;
            c.alu_op = 2'b10;
            push(dont_care_mr(tie), c);
            c = active();
            c.reg_write = 1'b1;
            c.reg_dest  = 1'b1;
            push(dont_care_mr(tie), c);
        end else if (op == T_BEQ) begin
            c = active();
            c.src_a  = 1'b1;
            c.alu_op = 2'b01;
            c.branch = 1'b1;
            c.pc_src = 2'b01;
            push(dont_care_mr(tie), c);
        end else if (op == T_ADDI) begin
            c = active();
            c.src_a = 1'b1;
            c.src_b = 2'b10;
            push(dont_care_mr(tie), c);
            c = active();
            c.reg_write = 1'b1;
            push(dont_care_mr(tie), c);
        end else if (op == T_J) begin
            c = active();
            c.pc_write = 1'b1;
            c.pc_src   = 2'b10;
            push(dont_care_mr(tie), c);
        end
    endfunction

    // Plays the built trace from a FETCH cycle; en toggles freely since it only matters in IDLE
    task automatic run_trace(input string name, input logic [5:0] op, input int limit);
        ctl_t got;
        cnt_mem_write = 0;
        cnt_reg_write = 0;
        cnt_illegal   = 0;
        for (int i = 0; i < q_exp.size() && i < limit; i++) begin
            @(negedge clk);
            if (i == 0) opcode = op;
            mem_ready = q_mr[i];
            en        = 1'($urandom_range(0, 1));
            #1;
            got = observe();
            cnt_mem_write += int'(mem_write);
            cnt_reg_write += int'(reg_write);
            cnt_illegal   += int'(illegal_op);
            checks++;
            if (got !== q_exp[i]) begin
                failures++;
                $display("FAIL %s op=%b cycle %0d: got %h required %h", name, op, i, got, q_exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        ctl_t got;
        rst_n     = 1'b0;
        en        = 1'b1;
        mem_ready = 1'b1;
        opcode    = T_LW;
        #3;
        got = observe();
        checks++;
        if (got !== ctl_t'(0)) begin
            failures++;
            $display("FAIL reset_outputs: got %h required %h", got, ctl_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en        = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            got = observe();
            checks++;
            if (got !== ctl_t'(0)) begin
                failures++;
                $display("FAIL idle_hold cycle %0d: got %h required %h", i, got, ctl_t'(0));
            end
        end
        @(negedge clk);
        en = 1'b1;
        #1;
        got = observe();
        checks++;
        if (got !== ctl_t'(0)) begin
            failures++;
            $display("FAIL idle_en_cycle: got %h required %h", got, ctl_t'(0));
        end
    endtask

    task automatic test_fetch_wait();
        build(T_R, 3, 0, 1'b0);
        run_trace("fetch_wait", T_R, 1000);
    endtask

    task automatic test_lw();
        build(T_LW, 0, 0, 1'b1);
        run_trace("lw", T_LW, 1000);
    endtask

    task automatic test_sw_wait();
        build(T_SW, 0, 2, 1'b0);
        run_trace("sw_wait", T_SW, 1000);
        checks++;
        if (cnt_mem_write != 3) begin
            failures++;
            $display("FAIL sw_mem_write_cycles: got %0d required 3", cnt_mem_write);
        end
        checks++;
        if (cnt_reg_write != 0) begin
            failures++;
            $display("FAIL sw_reg_write_cycles: got %0d required 0", cnt_reg_write);
        end
    endtask

    // Counts cycles from one FETCH to the next with memory always ready, then finishes with a jump
    task automatic measure(input string name, input logic [5:0] op, input int exp_cycles);
        int k    = 0;
        bit done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (n == 0) opcode = op;
            mem_ready = 1'b1;
            #1;
            if (n > 0 && busy && alu_src_b == 2'b01) done = 1'b1;
            else k++;
        end
        checks++;
        if (!done || k != exp_cycles) begin
            failures++;
            $display("FAIL latency_%s: got %0d cycles (returned=%0d) required %0d", name, k, done, exp_cycles);
        end
        opcode = T_J;
        repeat (2) begin
            @(negedge clk);
            mem_ready = 1'b1;
        end
    endtask

    task automatic test_mix();
        build(T_R, 0, 0, 1'b0);
        run_trace("mix_r", T_R, 1000);
        build(T_BEQ, 0, 0, 1'b0);
        run_trace("mix_beq", T_BEQ, 1000);
        build(T_J, 0, 0, 1'b0);
        run_trace("mix_j", T_J, 1000);
        measure("r", T_R, 4);
        measure("beq", T_BEQ, 3);
        measure("j", T_J, 3);
        measure("lw", T_LW, 5);
        measure("sw", T_SW, 4);
        measure("addi", T_ADDI, 4);
        measure("illegal", T_BAD, 2);
    endtask

    task automatic test_illegal();
        build(T_BAD, 1, 0, 1'b0);
        run_trace("illegal", T_BAD, 1000);
        checks++;
        if (cnt_illegal != 1) begin
            failures++;
            $display("FAIL illegal_pulse_cycles: got %0d required 1", cnt_illegal);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[6];
        logic [5:0] op;
        ops[0] = T_R;
        ops[1] = T_LW;
        ops[2] = T_SW;
        ops[3] = T_BEQ;
        ops[4] = T_ADDI;
        ops[5] = T_J;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            build(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
            run_trace("random", op, 1000);
        end
    endtask

    task automatic test_reset_mid_memwr();
        ctl_t got;
        build(T_SW, 0, 5, 1'b0);
        run_trace("memwr_pre_abort", T_SW, 5);
        rst_n = 1'b0;
        #1;
        got = observe();
        checks++;
        if (got !== ctl_t'(0)) begin
            failures++;
            $display("FAIL memwr_abort_outputs: got %h required %h", got, ctl_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        #1;
        got = observe();
        checks++;
        if (got !== ctl_t'(0)) begin
            failures++;
            $display("FAIL memwr_abort_idle: got %h required %h", got, ctl_t'(0));
        end
        @(negedge clk);
        en = 1'b1;
        build(T_LW, 1, 1, 1'b0);
        run_trace("post_abort_lw", T_LW, 1000);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fetch_wait();
        test_lw();
        test_sw_wait();
        test_mix();
        test_illegal();
        test_random();
        test_reset_mid_memwr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
